// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state codes, opcode/funct constants and datapath select encodings
// shared by the multicycle control unit and its ALU decoder.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_EXEC_I   = 4'd10,
    ST_I_WB     = 4'd11,
    ST_MULDIV   = 4'd12,
    ST_TRAP     = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5,
    ALU_XOR = 3'd6
  } alu_code_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Wide enough for the largest supported timeout (255).
  localparam int WAIT_W = 8;

  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// rtl/mc_alu_decode.sv - combinational ALU function and legality decode from state/opcode/funct;
// MC_CTRL_MULDIV_EN makes the mult/div functs legal in EXEC_R.
module mc_alu_decode
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_code_t  alu_code,
  output logic       decode_illegal
);

  always_comb begin
    alu_code       = ALU_ADD;
    decode_illegal = 1'b0;
    case (state)
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: decode_illegal = 1'b0;
          default:                           decode_illegal = 1'b1;
        endcase
      end
      ST_EXEC_R: begin
        case (funct)
          FN_ADD: alu_code = ALU_ADD;
          FN_SUB: alu_code = ALU_SUB;
          FN_AND: alu_code = ALU_AND;
          FN_OR:  alu_code = ALU_OR;
          FN_SLT: alu_code = ALU_SLT;
          FN_NOR: alu_code = ALU_NOR;
          FN_XOR: alu_code = ALU_XOR;
`ifdef MC_CTRL_MULDIV_EN
          FN_MULT, FN_DIV: alu_code = ALU_ADD;
`endif
          default: decode_illegal = 1'b1;
        endcase
      end
      ST_EXEC_I: begin
        case (opcode)
          OP_SLTI: alu_code = ALU_SLT;
          OP_ANDI: alu_code = ALU_AND;
          OP_ORI:  alu_code = ALU_OR;
          default: alu_code = ALU_ADD;
        endcase
      end
      ST_BRANCH: alu_code = ALU_SUB;
      default:   alu_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS control FSM with memory-ready timeout and sticky trap;
// defining MC_CTRL_MULDIV_EN adds mult/div sequencing through the MULDIV state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int ALU_OP_W    = 4,
  parameter int STATE_W     = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  input  logic                zero,
  input  logic                alu_busy,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                i_or_d,
  output logic                reg_read,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                muldiv_start,
  output logic                illegal,
  output logic [STATE_W-1:0]  s_actual
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              is_sw_q, is_sw_d;
  logic              is_bne_q, is_bne_d;
  alu_code_t         alu_code;
  logic              decode_illegal;
  logic              mem_state;
  logic              timed_out;
  logic              muldiv_funct;

  mc_alu_decode u_alu_decode (
    .state          (state_q),
    .opcode         (opcode),
    .funct          (funct),
    .alu_code       (alu_code),
    .decode_illegal (decode_illegal)
  );

  assign mem_state = is_mem_state(state_q);
  // A ready in the last allowed cycle completes the access instead of trapping.
  assign timed_out = mem_state && !mem_ready && (wait_q == WAIT_LAST);

`ifdef MC_CTRL_MULDIV_EN
  logic md_first_q, md_first_d;
  assign muldiv_funct = (funct == FN_MULT) || (funct == FN_DIV);
`else
  logic unused_alu_busy;
  assign muldiv_funct    = 1'b0;
  assign unused_alu_busy = alu_busy;
`endif

  always_comb begin
    state_d  = state_q;
    is_sw_d  = is_sw_q;
    is_bne_d = is_bne_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready)      state_d = ST_DECODE;
        else if (timed_out) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        // Later states must not depend on the live IR fields, so latch what they need.
        is_sw_d  = (opcode == OP_SW);
        is_bne_d = (opcode == OP_BNE);
        if (decode_illegal) begin
          state_d = ST_TRAP;
        end else begin
          case (opcode)
            OP_RTYPE:       state_d = ST_EXEC_R;
            OP_LW, OP_SW:   state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE: state_d = ST_BRANCH;
            OP_J:           state_d = ST_JUMP;
            default:        state_d = ST_EXEC_I;
          endcase
        end
      end
      ST_EXEC_R: begin
        if (decode_illegal)    state_d = ST_TRAP;
        else if (muldiv_funct) state_d = ST_MULDIV;
        else                   state_d = ST_R_WB;
      end
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_MEM_ADDR: state_d = is_sw_q ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready)      state_d = ST_MEM_WB;
        else if (timed_out) state_d = ST_TRAP;
      end
      ST_MEM_WR: begin
        if (mem_ready)      state_d = ST_FETCH;
        else if (timed_out) state_d = ST_TRAP;
      end
      ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
      ST_MULDIV: begin
`ifdef MC_CTRL_MULDIV_EN
        if (!alu_busy) state_d = ST_FETCH;
`else
        state_d = ST_FETCH;
`endif
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    if (state_d != state_q)          wait_d = '0;
    else if (mem_state && !mem_ready) wait_d = wait_q + 1'b1;
    else                              wait_d = wait_q;

`ifdef MC_CTRL_MULDIV_EN
    md_first_d = (state_d == ST_MULDIV) && (state_q != ST_MULDIV);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      wait_q   <= '0;
      is_sw_q  <= 1'b0;
      is_bne_q <= 1'b0;
`ifdef MC_CTRL_MULDIV_EN
      md_first_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      is_sw_q  <= is_sw_d;
      is_bne_q <= is_bne_d;
`ifdef MC_CTRL_MULDIV_EN
      md_first_q <= md_first_d;
`endif
    end
  end

  // Outputs are forced low during reset so an aborted instruction issues nothing.
  always_comb begin
    pc_write     = 1'b0;
    pc_src       = PCSRC_ALU;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    reg_read     = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    muldiv_start = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        ST_DECODE: begin
          reg_read  = 1'b1;
          alu_src_b = SRCB_IMM_SH2;
        end
        ST_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        ST_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
        end
        ST_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        ST_BRANCH: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_B;
          pc_src    = PCSRC_ALUOUT;
          pc_write  = is_bne_q ? !zero : zero;
        end
        ST_JUMP: begin
          pc_src   = PCSRC_JUMP;
          pc_write = 1'b1;
        end
        ST_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        ST_I_WB: reg_write = 1'b1;
`ifdef MC_CTRL_MULDIV_EN
        ST_MULDIV: muldiv_start = md_first_q;
`endif
        ST_TRAP: illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

  assign alu_op   = reset ? '0 : ALU_OP_W'(alu_code);
  assign s_actual = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - directed scoreboard bench for mc_control_fsm; the MULDIV step
// follows MC_CTRL_MULDIV_EN.
module tb_mc_control_fsm;

  localparam int TO = 15;
  localparam int PCW = 15, PCS = 13, IRW = 12, IOD = 11, RRD = 10, RWR = 9, RDST = 8;
  localparam int M2R = 7, ASA = 6, ASB = 4, MRD = 3, MWR = 2, MDS = 1, ILL = 0;
  localparam logic [15:0] STROBES = 16'h960F;
  localparam logic [3:0]  NOCHK   = 4'hF;
  localparam logic [3:0] S_FE = 4'd0, S_DE = 4'd1, S_MA = 4'd2, S_MR = 4'd3, S_MB = 4'd4;
  localparam logic [3:0] S_MW = 4'd5, S_ER = 4'd6, S_RW = 4'd7, S_BR = 4'd8, S_JP = 4'd9;
  localparam logic [3:0] S_EI = 4'd10, S_IW = 4'd11, S_MD = 4'd12, S_TR = 4'd15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       zero = 1'b0;
  logic       alu_busy = 1'b0;
  logic       pc_write, ir_write, i_or_d, reg_read, reg_write, reg_dst, mem_to_reg;
  logic       alu_src_a, mem_read, mem_write, muldiv_start, illegal;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_op, s_actual;
  logic [15:0] obs;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [63:0] tag;
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic        busy;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        mdf;
    logic [3:0]  alu;
  } step_t;

  step_t sb[$];

  mc_control_fsm #(.ALU_OP_W(4), .STATE_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .zero(zero), .alu_busy(alu_busy), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .i_or_d(i_or_d), .reg_read(reg_read), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .muldiv_start(muldiv_start), .illegal(illegal), .s_actual(s_actual)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_src, ir_write, i_or_d, reg_read, reg_write, reg_dst,
                mem_to_reg, alu_src_a, alu_src_b, mem_read, mem_write, muldiv_start, illegal};

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input logic [63:0] tag, input logic [3:0] st, input logic mr,
                      input logic z, input logic busy, input logic [5:0] op,
                      input logic [5:0] fn, input logic mdf, input logic [3:0] alu);
    step_t e;
    e.tag = tag; e.st = st; e.mr = mr; e.z = z; e.busy = busy;
    e.op = op; e.fn = fn; e.mdf = mdf; e.alu = alu;
    sb.push_back(e);
  endtask

  task automatic ps(input logic [63:0] tag, input logic [3:0] st, input logic mr,
                    input logic [5:0] op, input logic [5:0] fn, input logic [3:0] alu);
    push(tag, st, mr, 1'b0, 1'b0, op, fn, 1'b0, alu);
  endtask

  // Expected outputs per state: strobes are always checked, selects only where named.
  function automatic void spec_exp(input step_t e, output logic [15:0] v, output logic [15:0] m,
                                   output logic [3:0] a, output logic ac);
    v = '0; m = STROBES; a = 4'd0; ac = 1'b0;
    case (e.st)
      S_FE: begin
        v[MRD] = 1'b1; v[IRW] = e.mr; v[PCW] = e.mr;
        m[IOD] = 1'b1; m[ASA] = 1'b1; m[PCS+:2] = 2'b11;
        v[ASB+:2] = 2'b01; m[ASB+:2] = 2'b11; ac = 1'b1;
      end
      S_DE: begin v[RRD] = 1'b1; v[ASB+:2] = 2'b11; m[ASB+:2] = 2'b11; ac = 1'b1; end
      S_MA: begin v[ASB+:2] = 2'b10; m[ASB+:2] = 2'b11; ac = 1'b1; end
      S_MR: begin v[MRD] = 1'b1; v[IOD] = 1'b1; m[IOD] = 1'b1; end
      S_MB: begin v[RWR] = 1'b1; v[M2R] = 1'b1; m[M2R] = 1'b1; end
      S_MW: begin v[MWR] = 1'b1; v[IOD] = 1'b1; m[IOD] = 1'b1; end
      S_ER: begin
        v[ASA] = 1'b1; m[ASA] = 1'b1; m[ASB+:2] = 2'b11;
        a = e.alu; ac = (e.alu != NOCHK);
      end
      S_RW: begin v[RWR] = 1'b1; v[RDST] = 1'b1; m[RDST] = 1'b1; m[M2R] = 1'b1; end
      S_BR: begin
        v[PCS+:2] = 2'b01; m[PCS+:2] = 2'b11;
        v[PCW] = (e.op == 6'h05) ? !e.z : e.z; a = 4'd1; ac = 1'b1;
      end
      S_JP: begin v[PCS+:2] = 2'b10; m[PCS+:2] = 2'b11; v[PCW] = 1'b1; end
      S_EI: begin v[ASB+:2] = 2'b10; m[ASB+:2] = 2'b11; a = e.alu; ac = 1'b1; end
      S_IW: begin v[RWR] = 1'b1; m[RDST] = 1'b1; end
      S_MD: v[MDS] = e.mdf;
      S_TR: v[ILL] = 1'b1;
      default: v = '0;
    endcase
  endfunction

  task automatic run_sb();
    step_t e;
    logic [15:0] v, m;
    logic [3:0] a;
    logic ac;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge clk);
      reset = 1'b0; mem_ready = e.mr; zero = e.z; alu_busy = e.busy;
      opcode = e.op; funct = e.fn;
      #1;
      spec_exp(e, v, m, a, ac);
      chk($sformatf("%0s/state", e.tag), 32'(s_actual), 32'(e.st));
      chk($sformatf("%0s/strobes@%0d", e.tag, e.st), 32'(obs & m), 32'(v & m));
      if (ac) chk($sformatf("%0s/alu_op@%0d", e.tag, e.st), 32'(alu_op), 32'(a));
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; alu_busy = 1'b1;
      #1;
      chk("reset/state", 32'(s_actual), 32'd0);
      chk("reset/strobes", 32'(obs), 32'd0);
      chk("reset/alu_op", 32'(alu_op), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(3);

    // R-type: add, sub, slt, nor, xor
    ps("add", S_FE, 1, 6'h00, 6'h20, 0); ps("add", S_DE, 1, 6'h00, 6'h20, 0);
    ps("add", S_ER, 1, 6'h00, 6'h20, 0); ps("add", S_RW, 1, 6'h00, 6'h20, 0);
    ps("sub", S_FE, 1, 6'h00, 6'h22, 0); ps("sub", S_DE, 1, 6'h00, 6'h22, 0);
    ps("sub", S_ER, 1, 6'h00, 6'h22, 1); ps("sub", S_RW, 1, 6'h00, 6'h22, 0);
    ps("slt", S_FE, 1, 6'h00, 6'h2A, 0); ps("slt", S_DE, 1, 6'h00, 6'h2A, 0);
    ps("slt", S_ER, 1, 6'h00, 6'h2A, 4); ps("slt", S_RW, 1, 6'h00, 6'h2A, 0);
    ps("nor", S_FE, 1, 6'h00, 6'h27, 0); ps("nor", S_DE, 1, 6'h00, 6'h27, 0);
    ps("nor", S_ER, 1, 6'h00, 6'h27, 5); ps("nor", S_RW, 1, 6'h00, 6'h27, 0);
    ps("xor", S_FE, 1, 6'h00, 6'h26, 0); ps("xor", S_DE, 1, 6'h00, 6'h26, 0);
    ps("xor", S_ER, 1, 6'h00, 6'h26, 6); ps("xor", S_RW, 1, 6'h00, 6'h26, 0);
    // lw with two extra wait cycles in MEM_RD; opcode is scrambled after DECODE
    ps("lw", S_FE, 1, 6'h23, 6'h00, 0); ps("lw", S_DE, 1, 6'h23, 6'h00, 0);
    ps("lw", S_MA, 1, 6'h2B, 6'h00, 0); ps("lw", S_MR, 0, 6'h2B, 6'h00, 0);
    ps("lw", S_MR, 0, 6'h3F, 6'h00, 0); ps("lw", S_MR, 1, 6'h3F, 6'h00, 0);
    ps("lw", S_MB, 1, 6'h00, 6'h00, 0);
    // sw with one fetch wait
    ps("sw", S_FE, 0, 6'h2B, 6'h00, 0); ps("sw", S_FE, 1, 6'h2B, 6'h00, 0);
    ps("sw", S_DE, 1, 6'h2B, 6'h00, 0); ps("sw", S_MA, 1, 6'h23, 6'h00, 0);
    ps("sw", S_MW, 1, 6'h23, 6'h00, 0);
    // branches: beq/bne with zero high and low
    ps("beq1", S_FE, 1, 6'h04, 6'h00, 0); ps("beq1", S_DE, 1, 6'h04, 6'h00, 0);
    push("beq1", S_BR, 1, 1, 0, 6'h04, 6'h00, 0, 1);
    ps("beq0", S_FE, 1, 6'h04, 6'h00, 0); ps("beq0", S_DE, 1, 6'h04, 6'h00, 0);
    push("beq0", S_BR, 1, 0, 0, 6'h04, 6'h00, 0, 1);
    ps("bne1", S_FE, 1, 6'h05, 6'h00, 0); ps("bne1", S_DE, 1, 6'h05, 6'h00, 0);
    push("bne1", S_BR, 1, 1, 0, 6'h05, 6'h00, 0, 1);
    ps("bne0", S_FE, 1, 6'h05, 6'h00, 0); ps("bne0", S_DE, 1, 6'h05, 6'h00, 0);
    push("bne0", S_BR, 1, 0, 0, 6'h05, 6'h00, 0, 1);
    ps("j", S_FE, 1, 6'h02, 6'h00, 0); ps("j", S_DE, 1, 6'h02, 6'h00, 0);
    ps("j", S_JP, 1, 6'h02, 6'h00, 0);
    // I-type
    ps("addi", S_FE, 1, 6'h08, 6'h00, 0); ps("addi", S_DE, 1, 6'h08, 6'h00, 0);
    ps("addi", S_EI, 1, 6'h08, 6'h00, 0); ps("addi", S_IW, 1, 6'h08, 6'h00, 0);
    ps("slti", S_FE, 1, 6'h0A, 6'h00, 0); ps("slti", S_DE, 1, 6'h0A, 6'h00, 0);
    ps("slti", S_EI, 1, 6'h0A, 6'h00, 4); ps("slti", S_IW, 1, 6'h0A, 6'h00, 0);
    ps("andi", S_FE, 1, 6'h0C, 6'h00, 0); ps("andi", S_DE, 1, 6'h0C, 6'h00, 0);
    ps("andi", S_EI, 1, 6'h0C, 6'h00, 2); ps("andi", S_IW, 1, 6'h0C, 6'h00, 0);
    ps("ori", S_FE, 1, 6'h0D, 6'h00, 0); ps("ori", S_DE, 1, 6'h0D, 6'h00, 0);
    ps("ori", S_EI, 1, 6'h0D, 6'h00, 3); ps("ori", S_IW, 1, 6'h0D, 6'h00, 0);
    // abort a lw while it waits in MEM_RD
    ps("lwabort", S_FE, 1, 6'h23, 6'h00, 0); ps("lwabort", S_DE, 1, 6'h23, 6'h00, 0);
    ps("lwabort", S_MA, 1, 6'h23, 6'h00, 0); ps("lwabort", S_MR, 0, 6'h23, 6'h00, 0);
    run_sb();
    do_reset(2);

    // illegal opcode: sticky for 20 cycles regardless of inputs
    ps("ill", S_FE, 1, 6'h3F, 6'h00, 0); ps("ill", S_DE, 1, 6'h3F, 6'h00, 0);
    for (int i = 0; i < 20; i++) ps("ill", S_TR, i[0], 6'h00, 6'h20, 0);
    run_sb();
    do_reset(1);

    // unknown funct traps after EXEC_R
    ps("badfn", S_FE, 1, 6'h00, 6'h01, 0); ps("badfn", S_DE, 1, 6'h00, 6'h01, 0);
    ps("badfn", S_ER, 1, 6'h00, 6'h01, NOCHK); ps("badfn", S_TR, 1, 6'h00, 6'h01, 0);
    run_sb();
    do_reset(1);

    // fetch timeout, then ready on the last allowed cycle
    for (int i = 0; i < TO; i++) ps("fto", S_FE, 0, 6'h02, 6'h00, 0);
    ps("fto", S_TR, 1, 6'h02, 6'h00, 0); ps("fto", S_TR, 1, 6'h02, 6'h00, 0);
    run_sb();
    do_reset(1);
    for (int i = 0; i < TO - 1; i++) ps("fok", S_FE, 0, 6'h02, 6'h00, 0);
    ps("fok", S_FE, 1, 6'h02, 6'h00, 0); ps("fok", S_DE, 1, 6'h02, 6'h00, 0);
    ps("fok", S_JP, 1, 6'h02, 6'h00, 0); ps("fok", S_FE, 1, 6'h2B, 6'h00, 0);
    // store timeout in MEM_WR
    ps("wto", S_DE, 1, 6'h2B, 6'h00, 0); ps("wto", S_MA, 1, 6'h2B, 6'h00, 0);
    for (int i = 0; i < TO; i++) ps("wto", S_MW, 0, 6'h2B, 6'h00, 0);
    ps("wto", S_TR, 0, 6'h2B, 6'h00, 0);
    run_sb();
    do_reset(1);

    // mult with alu_busy high for 5 cycles
    ps("mult", S_FE, 1, 6'h00, 6'h18, 0); ps("mult", S_DE, 1, 6'h00, 6'h18, 0);
    ps("mult", S_ER, 1, 6'h00, 6'h18, NOCHK);
`ifdef MC_CTRL_MULDIV_EN
    push("mult", S_MD, 0, 0, 1, 6'h00, 6'h18, 1, 0);
    for (int i = 0; i < 4; i++) push("mult", S_MD, 0, 0, 1, 6'h00, 6'h18, 0, 0);
    push("mult", S_MD, 0, 0, 0, 6'h00, 6'h18, 0, 0);
    ps("mult", S_FE, 1, 6'h00, 6'h20, 0);
`else
    push("mult", S_TR, 1, 0, 1, 6'h00, 6'h18, 0, 0);
    push("mult", S_TR, 1, 0, 0, 6'h00, 6'h18, 0, 0);
`endif
    run_sb();
    do_reset(1);
    ps("final", S_FE, 0, 6'h00, 6'h00, 0);
    run_sb();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
